// File: rtl/vdf_ctrl_pkg.sv
// vdf_ctrl_pkg: shared states, status codes and sizing for the
// VDF squaring controller and its iteration counter.
package vdf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        ABORTED = 2'd1,
        TIMEOUT = 2'd2
    } status_t;

    localparam int NONREDUNDANT_ELEMENTS = 1024 / 17;
    localparam int SQ_OUT_BITS           = 62 * 17 * 2;

    // Width of a counter that must reach n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vdf_iter_counter.sv
// vdf_iter_counter: counts completed squarings, flags the final one
// and flags a stalled squarer after too long a gap between results.
module vdf_iter_counter
    import vdf_ctrl_pkg::*;
#(
    parameter int T_LEN          = 64,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             run,
    input  logic             sq_valid,
    input  logic [T_LEN-1:0] target,
    output logic [T_LEN-1:0] iter_count,
    output logic             last_iter,
    output logic             timed_out
);

    localparam int            TW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] gap_cnt;

    // Count results and idle gaps only while the squarer is running
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iter_count <= '0;
            gap_cnt    <= '0;
        end else if (clear) begin
            iter_count <= '0;
            gap_cnt    <= '0;
        end else if (run) begin
            if (sq_valid) begin
                if (iter_count != '1) begin
                    iter_count <= iter_count + T_LEN'(1);
                end
                gap_cnt <= '0;
            end else if (gap_cnt != TO_LAST) begin
                gap_cnt <= gap_cnt + TW'(1);
            end
        end
    end

    assign last_iter = run && sq_valid
                     && (iter_count == target - T_LEN'(1));

    assign timed_out = run && !sq_valid && (gap_cnt == TO_LAST);

endmodule

// File: rtl/vdf_squaring_controller.sv
// vdf_squaring_controller: loads and starts the squarer, waits for T
// results, flushes the squarer and hands the result to the host.
module vdf_squaring_controller #(
    parameter int MOD_LEN        = 1024,
    parameter int WORD_LEN       = 17,
    parameter int NUM_ELEMENTS   = 62,
    parameter int SQ_OUT_BITS    = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int T_LEN          = 64,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FLUSH_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [MOD_LEN-1:0]     cmd_sq_in,
    input  logic [T_LEN-1:0]       cmd_iters,
    input  logic                   abort,
    output logic                   sq_reset,
    output logic                   sq_start,
    output logic [MOD_LEN-1:0]     sq_in,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [SQ_OUT_BITS-1:0] result_data,
    output logic [1:0]             result_status,
    output logic [T_LEN-1:0]       iter_count,
    output logic                   busy
);

    import vdf_ctrl_pkg::*;

    localparam int            NR_WORDS   = MOD_LEN / WORD_LEN;
    localparam int            SLOT_BITS  = 2 * WORD_LEN;
    localparam int            FW         = cnt_width(FLUSH_CYCLES);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t           state;
    status_t          status_q;
    logic [T_LEN-1:0] target;
    logic [FW-1:0]    flush_cnt;
    logic             accept;
    logic             running;
    logic             last_iter;
    logic             timed_out;

    // With T=0 the answer is x itself, spread one word per slot.
    function automatic logic [SQ_OUT_BITS-1:0] spread_words(
        input logic [MOD_LEN-1:0] x
    );
        logic [SQ_OUT_BITS-1:0] r;
        r = '0;
        for (int j = 0; j < NR_WORDS; j++) begin
            r[j*SLOT_BITS +: WORD_LEN] = x[j*WORD_LEN +: WORD_LEN];
        end
        return r;
    endfunction

    assign accept        = (state == IDLE) && cmd_valid && cmd_ready;
    assign running       = (state == RUN);
    assign result_status = status_q;

    vdf_iter_counter #(
        .T_LEN          (T_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) iter_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (accept),
        .run        (running),
        .sq_valid   (sq_valid),
        .target     (target),
        .iter_count (iter_count),
        .last_iter  (last_iter),
        .timed_out  (timed_out)
    );

    // Run sequencing with every host and squarer output registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            status_q     <= OK;
            cmd_ready    <= 1'b1;
            sq_reset     <= 1'b1;
            sq_start     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            result_data  <= '0;
            sq_in        <= '0;
            target       <= '0;
            flush_cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sq_in     <= cmd_sq_in;
                        target    <= cmd_iters;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_iters == '0) begin
                            result_data  <= spread_words(cmd_sq_in);
                            status_q     <= OK;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            sq_reset <= 1'b0;
                            sq_start <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    sq_start <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (last_iter) begin
                        result_data <= sq_out;
                        status_q    <= OK;
                        sq_reset    <= 1'b1;
                        flush_cnt   <= '0;
                        state       <= FLUSH;
                    end else if (abort) begin
                        result_data <= '0;
                        status_q    <= ABORTED;
                        sq_reset    <= 1'b1;
                        flush_cnt   <= '0;
                        state       <= FLUSH;
                    end else if (timed_out) begin
                        result_data <= '0;
                        status_q    <= TIMEOUT;
                        sq_reset    <= 1'b1;
                        flush_cnt   <= '0;
                        state       <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        cmd_ready    <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdf_squaring_controller.sv
// tb_vdf_squaring_controller: random VDF runs against a behavioural
// squarer and an outcome model of the controller.
`timescale 1ns/1ps
module tb_vdf_squaring_controller;

    localparam int MOD_LEN        = 1024;
    localparam int WORD_LEN       = 17;
    localparam int NUM_ELEMENTS   = 62;
    localparam int SQ_OUT_BITS    = NUM_ELEMENTS * WORD_LEN * 2;
    localparam int T_LEN          = 64;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int FLUSH_CYCLES   = 4;
    localparam int SLOT           = 2 * WORD_LEN;
    localparam int SQ_PERIOD      = 8;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [MOD_LEN-1:0]     cmd_sq_in;
    logic [T_LEN-1:0]       cmd_iters;
    logic                   abort;
    logic                   sq_reset;
    logic                   sq_start;
    logic [MOD_LEN-1:0]     sq_in;
    logic [SQ_OUT_BITS-1:0] sq_out;
    logic                   sq_valid;
    logic                   result_valid;
    logic                   result_ready;
    logic [SQ_OUT_BITS-1:0] result_data;
    logic [1:0]             result_status;
    logic [T_LEN-1:0]       iter_count;
    logic                   busy;

    vdf_squaring_controller #(
        .MOD_LEN        (MOD_LEN),
        .WORD_LEN       (WORD_LEN),
        .NUM_ELEMENTS   (NUM_ELEMENTS),
        .SQ_OUT_BITS    (SQ_OUT_BITS),
        .T_LEN          (T_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FLUSH_CYCLES   (FLUSH_CYCLES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_sq_in     (cmd_sq_in),
        .cmd_iters     (cmd_iters),
        .abort         (abort),
        .sq_reset      (sq_reset),
        .sq_start      (sq_start),
        .sq_in         (sq_in),
        .sq_out        (sq_out),
        .sq_valid      (sq_valid),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data),
        .result_status (result_status),
        .iter_count    (iter_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Squarer model knobs and observations
    int stall_after = -1;
    int abort_idx   = -1;
    int abort_off   = 0;
    int abort_cyc   = 0;
    int start_cnt   = 0;
    int flush_len   = 0;
    int noreset_cnt = 0;
    int idx         = 0;
    int phase       = 0;
    bit active      = 1'b0;
    int pulse_cyc [int];
    logic [SQ_OUT_BITS-1:0] pulse_val [int];

    function automatic logic [SQ_OUT_BITS-1:0] make_out(input int i);
        logic [SQ_OUT_BITS-1:0] v;
        v = '0;
        for (int j = 1; j < NUM_ELEMENTS; j++) v[j*SLOT +: 32] = $urandom;
        v[31:0] = i;
        return v;
    endfunction

    // T=0 answer: successive 17-bit words of x, one per 34-bit slot.
    function automatic logic [SQ_OUT_BITS-1:0] t0_expect(
        input logic [MOD_LEN-1:0] x
    );
        logic [SQ_OUT_BITS-1:0] v;
        logic [MOD_LEN-1:0]     s;
        v = '0;
        s = x;
        for (int j = 0; j < MOD_LEN / WORD_LEN; j++) begin
            v[j*SLOT +: SLOT] = SLOT'(s % (1 << WORD_LEN));
            s = s >> WORD_LEN;
        end
        return v;
    endfunction

    // Behavioural squarer: one result every SQ_PERIOD cycles after start
    initial begin
        sq_valid = 1'b0;
        sq_out   = '0;
        abort    = 1'b0;
        forever begin
            @(negedge clk);
            if (sq_start) start_cnt++;
            if (busy && sq_reset && !result_valid) flush_len++;
            if (!sq_reset) noreset_cnt++;
            sq_valid = 1'b0;
            abort    = 1'b0;
            if (sq_reset) begin
                active = 1'b0;
                idx    = 0;
                phase  = 0;
            end else if (sq_start) begin
                active = 1'b1;
                phase  = 0;
            end else if (active) begin
                phase++;
                if (phase == SQ_PERIOD && idx != stall_after) begin
                    idx++;
                    phase          = 0;
                    sq_valid       = 1'b1;
                    sq_out         = make_out(idx);
                    pulse_val[idx] = sq_out;
                    pulse_cyc[idx] = cyc_n;
                end
                if (abort_idx > 0 && idx == abort_idx && phase == abort_off) begin
                    abort     = 1'b1;
                    abort_cyc = cyc_n;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic arm();
        start_cnt   = 0;
        flush_len   = 0;
        noreset_cnt = 0;
        pulse_cyc.delete();
        pulse_val.delete();
    endtask

    task automatic send_cmd(input logic [MOD_LEN-1:0] x,
                            input logic [T_LEN-1:0] t, output int c);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 0, 1);
        arm();
        cmd_valid = 1'b1;
        cmd_sq_in = x;
        cmd_iters = t;
        c = cyc_n;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rv(output int c);
        int n;
        n = 0;
        while (!result_valid && n < 3000) begin
            step();
            n++;
        end
        if (!result_valid) check("result_valid_wait", 0, 1);
        c = cyc_n;
    endtask

    task automatic check_data(input string tag,
                              input logic [SQ_OUT_BITS-1:0] exp);
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
            check($sformatf("%s_slot%0d", tag, j),
                  64'(result_data[j*SLOT +: SLOT]), 64'(exp[j*SLOT +: SLOT]));
        end
    endtask

    task automatic finish_rv(input string tag, input int exp_iter);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
        check({tag, "_rv_low"}, 64'(result_valid), 0);
        check({tag, "_busy_low"}, 64'(busy), 0);
        check({tag, "_iter_kept"}, iter_count, 64'(exp_iter));
    endtask

    // Normal completion of T squarings, checked from the squarer record
    task automatic run_ok(input string tag, input logic [MOD_LEN-1:0] x,
                          input int t);
        int c, r;
        send_cmd(x, T_LEN'(t), c);
        wait_rv(r);
        check({tag, "_starts"}, 64'(start_cnt), 1);
        check({tag, "_status"}, 64'(result_status), 0);
        check({tag, "_iters"}, iter_count, 64'(t));
        check({tag, "_flush"}, 64'(flush_len), FLUSH_CYCLES);
        check({tag, "_sq_in"}, 64'(sq_in == x), 1);
        if (pulse_cyc.exists(t)) begin
            check({tag, "_rv_cycle"}, 64'(r),
                  64'(pulse_cyc[t] + FLUSH_CYCLES + 1));
            check_data(tag, pulse_val[t]);
        end else begin
            check({tag, "_pulse_seen"}, 0, 1);
        end
        finish_rv(tag, t);
    endtask

    logic [MOD_LEN-1:0]     rx;
    logic [SQ_OUT_BITS-1:0] snap;

    initial begin
        int c, r, t;
        cmd_valid    = 1'b0;
        cmd_sq_in    = '0;
        cmd_iters    = '0;
        result_ready = 1'b0;
        reset_n      = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", 64'(cmd_ready), 1);
        check("rst_sq_reset", 64'(sq_reset), 1);
        check("rst_sq_start", 64'(sq_start), 0);
        check("rst_rv", 64'(result_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_iter", iter_count, 0);
        check("rst_data", 64'(|result_data), 0);
        check("rst_status", 64'(result_status), 0);
        reset_n = 1'b1;
        step();

        run_ok("t5", MOD_LEN'(3), 5);

        send_cmd(MOD_LEN'(17'h1FFFF), '0, c);
        wait_rv(r);
        check("t0_rv_cycle", 64'(r), 64'(c + 1));
        check("t0_status", 64'(result_status), 0);
        check("t0_no_start", 64'(start_cnt), 0);
        check("t0_in_reset", 64'(noreset_cnt), 0);
        check_data("t0", t0_expect(MOD_LEN'(17'h1FFFF)));
        finish_rv("t0", 0);

        for (int j = 0; j < MOD_LEN / 32; j++) rx[j*32 +: 32] = $urandom;
        send_cmd(rx, '0, c);
        wait_rv(r);
        check("t0r_rv_cycle", 64'(r), 64'(c + 1));
        check_data("t0r", t0_expect(rx));
        finish_rv("t0r", 0);

        abort_idx = 10;
        abort_off = 3;
        send_cmd(MOD_LEN'(7), T_LEN'(100), c);
        wait_rv(r);
        abort_idx = -1;
        check("abort_status", 64'(result_status), 1);
        check("abort_data", 64'(|result_data), 0);
        check("abort_iters", iter_count, 10);
        check("abort_flush", 64'(flush_len), FLUSH_CYCLES);
        check("abort_rv_cycle", 64'(r), 64'(abort_cyc + FLUSH_CYCLES + 1));
        finish_rv("abort", 10);

        stall_after = 3;
        send_cmd(MOD_LEN'(11), T_LEN'(10), c);
        wait_rv(r);
        stall_after = -1;
        check("to_status", 64'(result_status), 2);
        check("to_iters", iter_count, 3);
        check("to_data", 64'(|result_data), 0);
        if (pulse_cyc.exists(3)) begin
            check("to_rv_cycle", 64'(r),
                  64'(pulse_cyc[3] + TIMEOUT_CYCLES + FLUSH_CYCLES + 1));
        end else begin
            check("to_pulse_seen", 0, 1);
        end
        finish_rv("to", 3);

        t = $urandom_range(2, 6);
        abort_idx = t;
        abort_off = 0;
        send_cmd(MOD_LEN'(5), T_LEN'(t), c);
        wait_rv(r);
        abort_idx = -1;
        check("tie_status", 64'(result_status), 0);
        check("tie_iters", iter_count, 64'(t));
        if (pulse_val.exists(t)) check_data("tie", pulse_val[t]);
        else check("tie_pulse_seen", 0, 1);
        snap = result_data;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'b1;
            cmd_iters = '0;
            step();
            check("hold_rv", 64'(result_valid), 1);
            check("hold_cmd_ready", 64'(cmd_ready), 0);
            check("hold_data", 64'(result_data == snap), 1);
        end
        cmd_valid = 1'b0;
        step();
        check("hold_status", 64'(result_status), 0);
        finish_rv("tie", t);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < MOD_LEN / 32; j++) rx[j*32 +: 32] = $urandom;
            run_ok($sformatf("rnd%0d", k), rx, $urandom_range(1, 12));
        end

        send_cmd(MOD_LEN'(9), T_LEN'(50), c);
        repeat (40) step();
        check("mid_busy", 64'(busy), 1);
        reset_n = 1'b0;
        step();
        check("mid_rst_sq_reset", 64'(sq_reset), 1);
        check("mid_rst_rv", 64'(result_valid), 0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 1);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_iter", iter_count, 0);
        check("mid_rst_start", 64'(sq_start), 0);
        check("mid_rst_data", 64'(|result_data), 0);
        reset_n = 1'b1;
        step();
        run_ok("post_rst", MOD_LEN'(13), 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
